// File: rtl/pipe_hazard_cu.sv
// Decode classifier plus scoreboard-based hazard unit: forwarding selects, load-use stalls, redirect flush.
// Build option: define HAZARD_FWD_EN for operand forwarding; otherwise any in-flight writer interlocks decode.
module pipe_hazard_cu #(
    parameter int NSTG        = 2,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               d_inst,
    input  logic                      d_valid,
    input  logic                      x_redirect,
    output logic [2:0]                d_type,
    output logic                      d_rf_we,
    output logic                      d_stall,
    output logic                      d_kill,
    output logic [$clog2(NSTG+1)-1:0] fwd_a_sel,
    output logic [$clog2(NSTG+1)-1:0] fwd_b_sel,
    output logic [31:0]               perf_stall_cnt
);
    localparam int SW = $clog2(NSTG+1);

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       is_load, use_rs1, use_rs2;

    assign opcode = d_inst[6:0];
    assign rd     = d_inst[11:7];
    assign rs1    = d_inst[19:15];
    assign rs2    = d_inst[24:20];

    always_comb begin
        d_type  = 3'd7;
        is_load = 1'b0;
        case (opcode)
            7'b0110011: d_type = 3'd0;
            7'b0010011,
            7'b1100111,
            7'b1110011: d_type = 3'd1;
            7'b0000011: begin
                d_type  = 3'd1;
                is_load = 1'b1;
            end
            7'b0100011: d_type = 3'd2;
            7'b1100011: d_type = 3'd3;
            7'b0110111,
            7'b0010111: d_type = 3'd4;
            7'b1101111: d_type = 3'd5;
            default:    d_type = 3'd7;
        endcase
    end

    assign use_rs1 = (d_type <= 3'd3);
    assign use_rs2 = (d_type == 3'd0) || (d_type == 3'd2) || (d_type == 3'd3);
    assign d_rf_we = ((d_type == 3'd0) || (d_type == 3'd1) || (d_type == 3'd4) || (d_type == 3'd5))
                     && (rd != 5'd0);

    logic [NSTG:1] sb_valid;
    logic [NSTG:1] sb_load;
    logic [4:0]    sb_rd [NSTG:1];
    logic [1:0]    flush_cnt;
    logic          stall_a, stall_b;
    logic [SW-1:0] sel_a, sel_b;

`ifdef HAZARD_FWD_EN
    localparam int LOAD_READY = 1 + LOAD_LAT;
`else
    logic unused_cfg;
    assign unused_cfg = ^{sb_load, 32'(LOAD_LAT)};
`endif

    // Walk oldest to youngest so the youngest matching writer decides the outcome.
    always_comb begin
        stall_a = 1'b0;
        stall_b = 1'b0;
        sel_a   = '0;
        sel_b   = '0;
        for (int k = NSTG; k >= 1; k--) begin
            if (use_rs1 && (rs1 != 5'd0) && sb_valid[k] && (sb_rd[k] == rs1)) begin
`ifdef HAZARD_FWD_EN
                if (k < (sb_load[k] ? LOAD_READY : 1)) begin
                    stall_a = 1'b1;
                    sel_a   = '0;
                end else begin
                    stall_a = 1'b0;
                    sel_a   = SW'(k);
                end
`else
                stall_a = 1'b1;
`endif
            end
            if (use_rs2 && (rs2 != 5'd0) && sb_valid[k] && (sb_rd[k] == rs2)) begin
`ifdef HAZARD_FWD_EN
                if (k < (sb_load[k] ? LOAD_READY : 1)) begin
                    stall_b = 1'b1;
                    sel_b   = '0;
                end else begin
                    stall_b = 1'b0;
                    sel_b   = SW'(k);
                end
`else
                stall_b = 1'b1;
`endif
            end
        end
    end

    assign d_kill    = x_redirect | (flush_cnt != 2'd0);
    assign d_stall   = (stall_a | stall_b) & ~d_kill;
    assign fwd_a_sel = sel_a;
    assign fwd_b_sel = sel_b;

    logic unused_bits;
    assign unused_bits = ^{d_inst[31:25], d_inst[14:12]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid       <= '0;
            sb_load        <= '0;
            for (int k = 1; k <= NSTG; k++) sb_rd[k] <= 5'd0;
            flush_cnt      <= 2'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            for (int k = NSTG; k >= 2; k--) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_load[k]  <= sb_load[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
            sb_valid[1] <= d_valid & d_rf_we & ~d_stall & ~d_kill;
            sb_load[1]  <= is_load;
            sb_rd[1]    <= rd;

            if (x_redirect)
                flush_cnt <= 2'(FLUSH_DEPTH - 1);
            else if (flush_cnt != 2'd0)
                flush_cnt <= flush_cnt - 2'd1;

            if (d_stall && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_cu.sv
// Self-checking bench for pipe_hazard_cu: directed literal checks plus randomized traffic against an in-bench model.
module tb_pipe_hazard_cu;
    localparam int NSTG        = 2;
    localparam int LOAD_LAT    = 1;
    localparam int FLUSH_DEPTH = 2;
    localparam int SW          = $clog2(NSTG+1);

    localparam logic [31:0] ADD1  = 32'h003100B3;
    localparam logic [31:0] ADD4  = 32'h00508233;
    localparam logic [31:0] LW1   = 32'h00012083;
    localparam logic [31:0] SW1   = 32'h00112023;
    localparam logic [31:0] ADDI0 = 32'h00000013;
    localparam logic [31:0] ADDX0 = 32'h00500233;
    localparam logic [31:0] ADD6  = 32'h00020333;
    localparam logic [31:0] LW6   = 32'h00022303;
    localparam logic [31:0] ADD7  = 32'h000303B3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   d_inst = 32'd0;
    logic          d_valid = 1'b0;
    logic          x_redirect = 1'b0;
    logic [2:0]    d_type;
    logic          d_rf_we, d_stall, d_kill;
    logic [SW-1:0] fwd_a_sel, fwd_b_sel;
    logic [31:0]   perf_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_cu #(.NSTG(NSTG), .LOAD_LAT(LOAD_LAT), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .d_inst(d_inst), .d_valid(d_valid), .x_redirect(x_redirect),
        .d_type(d_type), .d_rf_we(d_rf_we), .d_stall(d_stall), .d_kill(d_kill),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    // In-flight writers indexed by how many stages ahead of decode they are.
    int          m_v  [1:4];
    int          m_rd [1:4];
    int          m_ld [1:4];
    int          m_flush = 0;
    logic [31:0] m_perf = 32'd0;

    initial for (int k = 1; k <= 4; k++) begin m_v[k] = 0; m_rd[k] = 0; m_ld[k] = 0; end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void lookup(input int rs, input bit used, output int sel, output int stall);
        int ready;
        sel = 0;
        stall = 0;
        if (!used || rs == 0) return;
        for (int k = 1; k <= NSTG; k++) begin
            if (m_v[k] != 0 && m_rd[k] == rs) begin
`ifdef HAZARD_FWD_EN
                ready = (m_ld[k] != 0) ? 1 + LOAD_LAT : 1;
                if (k < ready) stall = 1;
                else sel = k;
`else
                ready = 0;
                stall = 1;
`endif
                return;
            end
        end
    endfunction

    function automatic void model_eval(output int ty, output int we, output int st,
                                       output int kl, output int fa, output int fb);
        int op, rd, sa, sb;
        op = int'(d_inst[6:0]);
        rd = int'(d_inst[11:7]);
        case (op)
            'h33:                   ty = 0;
            'h13, 'h03, 'h67, 'h73: ty = 1;
            'h23:                   ty = 2;
            'h63:                   ty = 3;
            'h37, 'h17:             ty = 4;
            'h6f:                   ty = 5;
            default:                ty = 7;
        endcase
        we = ((ty == 0 || ty == 1 || ty == 4 || ty == 5) && rd != 0) ? 1 : 0;
        lookup(int'(d_inst[19:15]), ty <= 3, fa, sa);
        lookup(int'(d_inst[24:20]), ty == 0 || ty == 2 || ty == 3, fb, sb);
        kl = (x_redirect || m_flush != 0) ? 1 : 0;
        st = ((sa != 0 || sb != 0) && kl == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 1; k <= 4; k++) begin m_v[k] = 0; m_rd[k] = 0; m_ld[k] = 0; end
        m_flush = 0;
        m_perf  = 32'd0;
    endtask

    task automatic model_advance(input int we, input int st, input int kl);
        if (st != 0 && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
        if (x_redirect) m_flush = FLUSH_DEPTH - 1;
        else if (m_flush > 0) m_flush = m_flush - 1;
        for (int k = NSTG; k >= 2; k--) begin
            m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
        end
        m_v[1]  = (d_valid && we != 0 && st == 0 && kl == 0) ? 1 : 0;
        m_rd[1] = int'(d_inst[11:7]);
        m_ld[1] = (d_inst[6:0] == 7'h03) ? 1 : 0;
    endtask

    // Inputs only change just after a rising edge, so values seen here are those the next edge will use.
    always @(negedge clk) begin : compare
        int ty, we, st, kl, fa, fb;
        if (!rst_n) model_reset();
        model_eval(ty, we, st, kl, fa, fb);
        chk("d_type",  d_type,         ty);
        chk("d_rf_we", d_rf_we,        we);
        chk("d_stall", d_stall,        st);
        chk("d_kill",  d_kill,         kl);
        chk("fwd_a",   fwd_a_sel,      fa);
        chk("fwd_b",   fwd_b_sel,      fb);
        chk("perf",    perf_stall_cnt, m_perf);
        if (rst_n) model_advance(we, st, kl);
    end

    task automatic cyc(input logic [31:0] i, input logic v, input logic r);
        @(posedge clk);
        #1;
        d_inst = i; d_valid = v; x_redirect = r;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; d_valid = 1'b0; d_inst = 32'd0; x_redirect = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [6:0] ops [0:10];
    initial begin
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h67; ops[4] = 7'h73; ops[5] = 7'h23;
        ops[6] = 7'h63; ops[7] = 7'h37; ops[8] = 7'h17; ops[9] = 7'h6f; ops[10] = 7'h00;
    end

    initial begin
        logic [31:0] ri;
        do_reset();
        #1;
        chk("post_rst_stall", d_stall, 0);
        chk("post_rst_fwd_a", fwd_a_sel, 0);
        chk("post_rst_perf", perf_stall_cnt, 0);
        x_redirect = 1'b1;
        #1;
        chk("rst_kill_follows_redirect", d_kill, 1);
        x_redirect = 1'b0;

        cyc(ADD1, 1, 0);
        chk("add_type", d_type, 0);
        chk("add_we", d_rf_we, 1);
        chk("add_stall", d_stall, 0);
        chk("add_fwd_a", fwd_a_sel, 0);
        cyc(ADD4, 1, 0);
`ifdef HAZARD_FWD_EN
        chk("alu_fwd_a", fwd_a_sel, 1);
        chk("alu_fwd_b", fwd_b_sel, 0);
        chk("alu_no_stall", d_stall, 0);
`else
        chk("intlk_stall1", d_stall, 1);
        cyc(ADD4, 1, 0);
        chk("intlk_stall2", d_stall, 1);
        cyc(ADD4, 1, 0);
        chk("intlk_release", d_stall, 0);
        chk("intlk_fwd_a", fwd_a_sel, 0);
`endif

        do_reset();
        cyc(LW1, 1, 0);
        cyc(ADD4, 1, 0);
        chk("lu_stall", d_stall, 1);
        cyc(ADD4, 1, 0);
`ifdef HAZARD_FWD_EN
        chk("lu_release", d_stall, 0);
        chk("lu_fwd_a", fwd_a_sel, 2);
        chk("lu_perf", perf_stall_cnt, 1);
`else
        chk("lu_stall2", d_stall, 1);
        cyc(ADD4, 1, 0);
        chk("lu_release", d_stall, 0);
        chk("lu_perf", perf_stall_cnt, 2);
`endif

        do_reset();
        cyc(SW1, 1, 0);
        chk("sw_type", d_type, 2);
        chk("sw_we", d_rf_we, 0);
        cyc(ADDI0, 1, 0);
        chk("addi_x0_type", d_type, 1);
        chk("addi_x0_we", d_rf_we, 0);
        cyc(ADDX0, 1, 0);
        chk("read_x0_fwd_a", fwd_a_sel, 0);
        chk("read_x0_fwd_b", fwd_b_sel, 0);

        do_reset();
        cyc(LW1, 1, 0);
        cyc(ADD4, 1, 1);
        chk("fl_kill0", d_kill, 1);
        chk("fl_nostall0", d_stall, 0);
        cyc(ADD4, 1, 0);
        chk("fl_kill1", d_kill, 1);
        chk("fl_nostall1", d_stall, 0);
        cyc(ADD6, 1, 0);
        chk("fl_done", d_kill, 0);
        chk("fl_no_enq_fwd", fwd_a_sel, 0);
        chk("fl_no_enq_stall", d_stall, 0);

        do_reset();
        cyc(LW1, 1, 0);
        cyc(ADD4, 1, 1);
        cyc(ADD4, 1, 1);
        chk("refl_kill1", d_kill, 1);
        cyc(ADD4, 1, 0);
        chk("refl_kill2", d_kill, 1);
        chk("refl_nostall", d_stall, 0);
        cyc(ADD6, 1, 0);
        chk("refl_done", d_kill, 0);

        do_reset();
        cyc(LW1, 1, 0);
        cyc(ADD4, 1, 0);
        cyc(ADD4, 1, 0);
        cyc(LW6, 1, 0);
        cyc(ADD7, 1, 0);
        chk("mid_stall", d_stall, 1);
`ifdef HAZARD_FWD_EN
        chk("mid_perf", perf_stall_cnt, 1);
`else
        chk("mid_perf", perf_stall_cnt, 2);
`endif
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", d_stall, 0);
        chk("async_rst_fwd_a", fwd_a_sel, 0);
        chk("async_rst_fwd_b", fwd_b_sel, 0);
        chk("async_rst_perf", perf_stall_cnt, 0);
        chk("async_rst_kill", d_kill, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            ri        = $urandom;
            ri[6:0]   = ops[$urandom_range(0, 10)];
            ri[11:7]  = 5'($urandom_range(0, 3));
            ri[19:15] = 5'($urandom_range(0, 3));
            ri[24:20] = 5'($urandom_range(0, 3));
            cyc(ri, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
        end

        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
